// File: rtl/ysyx_25040111_lsu_resp.sv
// ysyx_25040111_lsu_resp: LSU responder that runs single/burst reads and masked writes on a word-wide
// memory port, handling lane selection, sign extension and byte strobes.
module ysyx_25040111_lsu_resp #(
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              lsu_rvalid,
    input  logic [ADDR_W-1:0] lsu_raddr,
    input  logic [7:0]        lsu_rlen,
    input  logic              lsu_burst,
    input  logic [1:0]        lsu_rmask,
    input  logic              lsu_rsign,
    output logic              lsu_rready,
    output logic [31:0]       lsu_rdata,
    input  logic              lsu_wvalid,
    input  logic [ADDR_W-1:0] lsu_waddr,
    input  logic [31:0]       lsu_wdata,
    input  logic [1:0]        lsu_wmask,
    output logic              lsu_wready,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);
    typedef enum logic [2:0] {IDLE, RREQ, RWAIT, RDATA, RDONE, WREQ, WRESP} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [1:0]        size_q, size_d;
    logic              sign_q, sign_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [4:0]        sh;
    logic [31:0]       lane;

    always_comb begin
        sh      = size_q[1] ? 5'd0 : size_q[0] ? {addr_q[1], 4'b0} : {addr_q[1:0], 3'b0};
        lane    = mem_rdata >> sh;
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        size_d  = size_q;
        sign_d  = sign_q;
        rdata_d = rdata_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        case (state_q)
            IDLE: begin
                if (lsu_wvalid) begin
                    addr_d  = lsu_waddr;
                    wstrb_d = lsu_wmask[1] ? 4'b1111 : lsu_wmask[0] ? 4'b0011 << {lsu_waddr[1], 1'b0}
                                                                    : 4'b0001 << lsu_waddr[1:0];
                    wdata_d = lsu_wmask[1] ? lsu_wdata : lsu_wmask[0] ? {2{lsu_wdata[15:0]}}
                                                                      : {4{lsu_wdata[7:0]}};
                    state_d = WREQ;
                end else if (lsu_rvalid) begin
                    addr_d  = lsu_raddr;
                    size_d  = lsu_burst ? 2'b10 : lsu_rmask;
                    sign_d  = lsu_rsign;
                    cnt_d   = lsu_burst ? lsu_rlen : 8'd0;
                    state_d = RREQ;
                end
            end
            RREQ: state_d = mem_ready ? RWAIT : RREQ;
            RWAIT: begin
                if (mem_rvalid) begin
                    rdata_d = size_q[1] ? lane
                            : size_q[0] ? {{16{sign_q & lane[15]}}, lane[15:0]}
                                        : {{24{sign_q & lane[7]}}, lane[7:0]};
                    state_d = RDATA;
                end
            end
            RDATA: begin
                if (cnt_q != 8'd0) begin
                    cnt_d   = cnt_q - 8'd1;
                    addr_d  = addr_q + ADDR_W'(4);
                    state_d = RREQ;
                end else begin
                    state_d = RDONE;
                end
            end
            RDONE: state_d = lsu_rvalid ? RDONE : IDLE;
            WREQ: state_d = mem_ready ? WRESP : WREQ;
            WRESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            size_q  <= '0;
            sign_q  <= 1'b0;
            rdata_q <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            rdata_q <= rdata_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end

    assign lsu_rready = state_q == RDATA;
    assign lsu_wready = state_q == WRESP;
    assign lsu_rdata  = rdata_q;
    assign mem_valid  = state_q == RREQ || state_q == WREQ;
    assign mem_we     = state_q == WREQ;
    assign mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_wdata  = wdata_q;
    assign mem_wstrb  = wstrb_q;
endmodule

// File: tb/tb_ysyx_25040111_lsu_resp.sv
// tb_ysyx_25040111_lsu_resp: randomized and directed bench with a variable-latency memory model
// and a transaction-level reference for lane selection, extension and strobes.
module tb_ysyx_25040111_lsu_resp;
    logic        clock = 1'b0, reset = 1'b0;
    logic        lsu_rvalid = 1'b0, lsu_burst = 1'b0, lsu_rsign = 1'b0;
    logic [31:0] lsu_raddr = '0, lsu_waddr = '0, lsu_wdata = '0;
    logic [7:0]  lsu_rlen = '0;
    logic [1:0]  lsu_rmask = '0, lsu_wmask = '0;
    logic        lsu_wvalid = 1'b0;
    logic        lsu_rready, lsu_wready, mem_valid, mem_we;
    logic [31:0] lsu_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready, mem_rvalid;
    logic [31:0] mem_rdata;

    ysyx_25040111_lsu_resp #(.ADDR_W(32)) dut (
        .clock(clock), .reset(reset),
        .lsu_rvalid(lsu_rvalid), .lsu_raddr(lsu_raddr), .lsu_rlen(lsu_rlen), .lsu_burst(lsu_burst),
        .lsu_rmask(lsu_rmask), .lsu_rsign(lsu_rsign), .lsu_rready(lsu_rready), .lsu_rdata(lsu_rdata),
        .lsu_wvalid(lsu_wvalid), .lsu_waddr(lsu_waddr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_wready(lsu_wready), .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    int n_chk = 0, n_fail = 0, cyc = 0, req_cyc = 0;
    int lat = 1, rdly = 0;
    bit ovr = 1'b0;
    logic [31:0] ovr_val = '0;
    logic [31:0] acc_addr[$], acc_wd[$], rd_q[$];
    logic        acc_we[$];
    logic [3:0]  acc_strb[$];
    int          rr_cyc[$], wr_cyc[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ovr ? ovr_val : ((a >> 2) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] w, input logic [31:0] a,
                                             input logic [1:0] m, input bit s);
        logic [31:0] v;
        if (m[1]) return w;
        if (m[0]) begin
            v = (w >> (16 * a[1])) & 32'hFFFF;
            return (s && v[15]) ? (v | 32'hFFFF_0000) : v;
        end
        v = (w >> (8 * a[1:0])) & 32'hFF;
        return (s && v[7]) ? (v | 32'hFFFF_FF00) : v;
    endfunction

    function automatic logic [3:0] exp_strb(input logic [31:0] a, input logic [1:0] m);
        return m[1] ? 4'hF : m[0] ? (a[1] ? 4'hC : 4'h3) : 4'(1 << a[1:0]);
    endfunction

    function automatic logic [31:0] exp_wd(input logic [31:0] d, input logic [1:0] m);
        return m[1] ? d : m[0] ? (d & 32'hFFFF) * 32'h0001_0001 : (d & 32'hFF) * 32'h0101_0101;
    endfunction

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Memory model and transaction monitor: samples at negedge, drives responses just after posedge.
    initial begin
        int pend, wcnt;
        bit stall;
        logic [31:0] paddr, sa, sd;
        logic [3:0] ss;
        logic swe;
        pend = -1; wcnt = 0; stall = 1'b0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                pend = -1;
                stall = 1'b0;
            end else begin
                if (stall) begin
                    n_chk++;
                    if (mem_valid !== 1'b1 || mem_addr !== sa || mem_we !== swe || mem_wstrb !== ss || mem_wdata !== sd) begin
                        n_fail++;
                        $display("FAIL stable: valid=%b addr=%h we=%b strb=%b wd=%h, required 1 %h %b %b %h",
                                 mem_valid, mem_addr, mem_we, mem_wstrb, mem_wdata, sa, swe, ss, sd);
                    end
                end
                if (mem_valid) begin
                    n_chk++;
                    if (mem_addr[1:0] !== 2'b00) begin
                        n_fail++;
                        $display("FAIL align: mem_addr=%h, required low bits 00", mem_addr);
                    end
                end
                stall = mem_valid && !mem_ready;
                sa = mem_addr; sd = mem_wdata; ss = mem_wstrb; swe = mem_we;
                if (mem_valid && mem_ready) begin
                    acc_addr.push_back(mem_addr); acc_we.push_back(mem_we);
                    acc_strb.push_back(mem_wstrb); acc_wd.push_back(mem_wdata);
                    if (!mem_we) begin
                        pend = lat;
                        paddr = mem_addr;
                    end
                end
                if (lsu_rready) begin
                    rd_q.push_back(lsu_rdata);
                    rr_cyc.push_back(cyc);
                end
                if (lsu_wready) wr_cyc.push_back(cyc);
            end
            @(posedge clock);
            #1;
            mem_rvalid = 1'b0;
            mem_rdata = $urandom;
            if (pend > 0 && reset) begin
                pend--;
                if (pend == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata = mem_word(paddr);
                    pend = -1;
                end
            end
            if (!mem_valid) begin
                wcnt = 0;
                mem_ready = 1'b0;
            end else begin
                mem_ready = wcnt >= rdly;
                wcnt++;
            end
        end
    end

    task automatic clear_logs();
        acc_addr.delete(); acc_we.delete(); acc_strb.delete(); acc_wd.delete();
        rd_q.delete(); rr_cyc.delete(); wr_cyc.delete();
    endtask

    task automatic start_read(input logic [31:0] a, input bit b, input logic [7:0] l,
                              input logic [1:0] m, input bit s);
        @(posedge clock);
        #1;
        lsu_rvalid = 1'b1; lsu_raddr = a; lsu_burst = b; lsu_rlen = l; lsu_rmask = m; lsu_rsign = s;
        req_cyc = cyc + 1;
    endtask

    task automatic finish_read(input int beats);
        int i;
        for (i = 0; i < 4000 && rr_cyc.size() < beats; i++) @(negedge clock);
        n_chk++;
        if (rr_cyc.size() < beats) begin
            n_fail++;
            $display("FAIL read_timeout: beats=%0d, required %0d", rr_cyc.size(), beats);
        end
        repeat (5) @(negedge clock);
        @(posedge clock);
        #1;
        lsu_rvalid = 1'b0;
        repeat (2) @(posedge clock);
    endtask

    task automatic start_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] m);
        @(posedge clock);
        #1;
        lsu_wvalid = 1'b1; lsu_waddr = a; lsu_wdata = d; lsu_wmask = m;
        req_cyc = cyc + 1;
    endtask

    task automatic finish_write();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clock);
            seen = lsu_wready;
        end
        lsu_wvalid = 1'b0;
        n_chk++;
        if (!seen) begin
            n_fail++;
            $display("FAIL write_timeout: wready=0, required 1");
        end
        @(posedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        n_chk++;
        if ({lsu_rready, lsu_rdata, lsu_wready, mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: rr=%b rd=%h wr=%b v=%b we=%b a=%h wd=%h s=%b, required all 0",
                     lsu_rready, lsu_rdata, lsu_wready, mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb);
        end
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(posedge clock);
    endtask

    task automatic test_word_read();
        clear_logs(); lat = 1; rdly = 0; ovr = 1'b1; ovr_val = 32'hDEAD_BEEF;
        start_read(32'h8000_0004, 1'b0, 8'd0, 2'b10, 1'b0);
        finish_read(1);
        n_chk++;
        if (rd_q.size() !== 1 || rd_q[0] !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL word_read: pulses=%0d data=%h, required 1 deadbeef", rd_q.size(), rd_q.size() ? rd_q[0] : 0);
        end
        n_chk++;
        if (rr_cyc.size() == 0 || rr_cyc[0] !== req_cyc + 2) begin
            n_fail++;
            $display("FAIL word_latency: cycle=%0d, required %0d", rr_cyc.size() ? rr_cyc[0] : -1, req_cyc + 2);
        end
        n_chk++;
        if (acc_addr.size() !== 1 || acc_addr[0] !== 32'h8000_0004 || acc_we[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL word_req: reqs=%0d, required 1 read at 80000004", acc_addr.size());
        end
        ovr = 1'b0;
    endtask

    task automatic test_byte_sign();
        logic [31:0] req[2];
        req[0] = 32'hFFFF_FF80; req[1] = 32'h0000_0080;
        ovr = 1'b1; ovr_val = 32'h80FF_0000; lat = 2; rdly = 1;
        for (int s = 0; s < 2; s++) begin
            clear_logs();
            start_read(32'h8000_0003, 1'b0, 8'd0, 2'b00, s == 0);
            finish_read(1);
            n_chk++;
            if (rd_q.size() !== 1 || rd_q[0] !== req[s]) begin
                n_fail++;
                $display("FAIL byte_sign%0d: pulses=%0d data=%h, required 1 %h", s, rd_q.size(), rd_q.size() ? rd_q[0] : 0, req[s]);
            end
        end
        ovr = 1'b0;
    endtask

    task automatic test_burst();
        clear_logs(); lat = 2; rdly = 0;
        start_read(32'h8000_0010, 1'b1, 8'd3, 2'b00, 1'b1);
        finish_read(4);
        n_chk++;
        if (acc_addr.size() !== 4 || rr_cyc.size() !== 4) begin
            n_fail++;
            $display("FAIL burst_count: reqs=%0d pulses=%0d, required 4 4", acc_addr.size(), rr_cyc.size());
        end
        for (int i = 0; i < 4 && i < acc_addr.size() && i < rd_q.size(); i++) begin
            n_chk++;
            if (acc_addr[i] !== 32'h8000_0010 + 4 * i || rd_q[i] !== mem_word(32'h8000_0010 + 4 * i)) begin
                n_fail++;
                $display("FAIL burst_beat%0d: addr=%h data=%h, required %h %h", i, acc_addr[i], rd_q[i],
                         32'h8000_0010 + 4 * i, mem_word(32'h8000_0010 + 4 * i));
            end
            if (i > 0) begin
                n_chk++;
                if (rr_cyc[i] - rr_cyc[i-1] !== 2 + lat) begin
                    n_fail++;
                    $display("FAIL burst_rate%0d: gap=%0d, required %0d", i, rr_cyc[i] - rr_cyc[i-1], 2 + lat);
                end
            end
        end
    endtask

    task automatic test_write_half();
        clear_logs(); rdly = 3;
        start_write(32'h8000_0006, 32'h0000_1234, 2'b01);
        finish_write();
        repeat (3) @(negedge clock);
        n_chk++;
        if (acc_addr.size() !== 1 || acc_we[0] !== 1'b1 || acc_strb[0] !== 4'b1100 ||
            acc_wd[0] !== 32'h1234_1234 || acc_addr[0] !== 32'h8000_0004) begin
            n_fail++;
            $display("FAIL write_half: reqs=%0d strb=%b wd=%h, required 1 1100 12341234",
                     acc_addr.size(), acc_strb.size() ? acc_strb[0] : 4'h0, acc_wd.size() ? acc_wd[0] : 0);
        end
        n_chk++;
        if (wr_cyc.size() !== 1 || wr_cyc[0] !== req_cyc + 1 + rdly) begin
            n_fail++;
            $display("FAIL write_pulse: pulses=%0d cycle=%0d, required 1 %0d", wr_cyc.size(),
                     wr_cyc.size() ? wr_cyc[0] : -1, req_cyc + 1 + rdly);
        end
    endtask

    task automatic test_both();
        clear_logs(); rdly = 0; lat = 1;
        start_write(32'h0000_0101, 32'h0000_00A5, 2'b00);
        lsu_rvalid = 1'b1; lsu_raddr = 32'h0000_0202; lsu_burst = 1'b0; lsu_rmask = 2'b01; lsu_rsign = 1'b1;
        finish_write();
        finish_read(1);
        n_chk++;
        if (acc_we.size() !== 2 || acc_we[0] !== 1'b1 || acc_we[1] !== 1'b0 || acc_strb[0] !== 4'b0010) begin
            n_fail++;
            $display("FAIL both_order: reqs=%0d, required write then read", acc_we.size());
        end
        n_chk++;
        if (rd_q.size() !== 1 || wr_cyc.size() !== 1 ||
            rd_q[0] !== exp_read(mem_word(32'h200), 32'h202, 2'b01, 1'b1) || wr_cyc[0] >= rr_cyc[0]) begin
            n_fail++;
            $display("FAIL both_result: rpulses=%0d wpulses=%0d data=%h, required 1 1 %h", rd_q.size(), wr_cyc.size(),
                     rd_q.size() ? rd_q[0] : 0, exp_read(mem_word(32'h200), 32'h202, 2'b01, 1'b1));
        end
    endtask

    task automatic test_reset_mid();
        clear_logs(); lat = 6; rdly = 0;
        start_read(32'h0000_0040, 1'b0, 8'd0, 2'b10, 1'b0);
        for (int i = 0; i < 50 && acc_addr.size() == 0; i++) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        n_chk++;
        if ({lsu_rready, lsu_rdata, lsu_wready, mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb} !== '0) begin
            n_fail++;
            $display("FAIL reset_rwait: v=%b a=%h rd=%h, required all 0", mem_valid, mem_addr, lsu_rdata);
        end
        lsu_rvalid = 1'b0;
        repeat (8) @(negedge clock);
        reset = 1'b1;
        clear_logs(); rdly = 5;
        start_write(32'h0000_0080, 32'hFFFF_FFFF, 2'b10);
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        n_chk++;
        if (mem_valid !== 1'b0 || mem_we !== 1'b0 || mem_wstrb !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_wreq: v=%b we=%b s=%b, required 0 0 0", mem_valid, mem_we, mem_wstrb);
        end
        lsu_wvalid = 1'b0;
        repeat (8) @(negedge clock);
        n_chk++;
        if (rr_cyc.size() !== 0 || wr_cyc.size() !== 0 || acc_addr.size() !== 0) begin
            n_fail++;
            $display("FAIL reset_abort: rpulses=%0d wpulses=%0d reqs=%0d, required 0 0 0", rr_cyc.size(), wr_cyc.size(), acc_addr.size());
        end
        reset = 1'b1;
        clear_logs(); lat = 1; rdly = 0;
        start_read(32'h0000_0044, 1'b0, 8'd0, 2'b11, 1'b0);
        finish_read(1);
        n_chk++;
        if (rd_q.size() !== 1 || rd_q[0] !== mem_word(32'h44)) begin
            n_fail++;
            $display("FAIL reset_recover: pulses=%0d data=%h, required 1 %h", rd_q.size(), rd_q.size() ? rd_q[0] : 0, mem_word(32'h44));
        end
    endtask

    task automatic test_random_reads();
        logic [31:0] a, wa;
        logic [1:0] m;
        logic [7:0] l;
        bit b, s;
        int beats;
        for (int t = 0; t < 24; t++) begin
            clear_logs();
            a = (t == 5) ? 32'hFFFF_FFF6 : $urandom;
            m = 2'($urandom); s = 1'($urandom); b = ($urandom_range(0, 3) == 0) || t == 5;
            l = 8'($urandom_range(0, 5));
            lat = $urandom_range(1, 4); rdly = $urandom_range(0, 3);
            beats = b ? l + 1 : 1;
            start_read(a, b, l, m, s);
            finish_read(beats);
            n_chk++;
            if (acc_addr.size() !== beats || rd_q.size() !== beats) begin
                n_fail++;
                $display("FAIL rnd_count%0d: reqs=%0d pulses=%0d, required %0d", t, acc_addr.size(), rd_q.size(), beats);
            end
            n_chk++;
            if (rr_cyc.size() == 0 || rr_cyc[0] !== req_cyc + 1 + rdly + lat) begin
                n_fail++;
                $display("FAIL rnd_latency%0d: cycle=%0d, required %0d", t, rr_cyc.size() ? rr_cyc[0] : -1, req_cyc + 1 + rdly + lat);
            end
            for (int i = 0; i < beats && i < acc_addr.size() && i < rd_q.size(); i++) begin
                wa = (a & 32'hFFFF_FFFC) + 4 * i;
                n_chk++;
                if (acc_addr[i] !== wa || rd_q[i] !== (b ? mem_word(wa) : exp_read(mem_word(wa), a, m, s))) begin
                    n_fail++;
                    $display("FAIL rnd_beat%0d_%0d: addr=%h data=%h, required %h %h", t, i, acc_addr[i], rd_q[i],
                             wa, b ? mem_word(wa) : exp_read(mem_word(wa), a, m, s));
                end
            end
        end
    endtask

    task automatic test_random_writes();
        logic [31:0] a, d;
        logic [1:0] m;
        for (int t = 0; t < 24; t++) begin
            clear_logs();
            a = $urandom; d = $urandom; m = 2'($urandom); rdly = $urandom_range(0, 3);
            start_write(a, d, m);
            finish_write();
            @(negedge clock);
            n_chk++;
            if (acc_addr.size() !== 1 || acc_we[0] !== 1'b1 || acc_addr[0] !== (a & 32'hFFFF_FFFC) ||
                acc_strb[0] !== exp_strb(a, m) || acc_wd[0] !== exp_wd(d, m)) begin
                n_fail++;
                $display("FAIL rnd_write%0d: reqs=%0d strb=%b wd=%h, required 1 %b %h", t, acc_addr.size(),
                         acc_strb.size() ? acc_strb[0] : 4'h0, acc_wd.size() ? acc_wd[0] : 0, exp_strb(a, m), exp_wd(d, m));
            end
            n_chk++;
            if (wr_cyc.size() !== 1 || wr_cyc[0] !== req_cyc + 1 + rdly) begin
                n_fail++;
                $display("FAIL rnd_wpulse%0d: pulses=%0d cycle=%0d, required 1 %0d", t, wr_cyc.size(),
                         wr_cyc.size() ? wr_cyc[0] : -1, req_cyc + 1 + rdly);
            end
        end
    endtask

    initial begin
        test_reset();
        test_word_read();
        test_byte_sign();
        test_burst();
        test_write_half();
        test_both();
        test_reset_mid();
        test_random_reads();
        test_random_writes();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
